// File: rtl/spm_pm_engine_pkg.sv
// rtl/spm_pm_engine_pkg.sv - shared state/op encodings and constants for the SPM program-memory engine
package spm_pm_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PROG = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_RWWSRE = 3'd1,
    OP_BLBSET = 3'd2,
    OP_PGWRT  = 3'd3,
    OP_PGERS  = 3'd4,
    OP_SPMEN  = 3'd5
  } op_t;

  localparam logic [15:0] ERASED_WORD = 16'hFFFF;

  // Erase wins over write so a page is never programmed while an erase is pending.
  function automatic op_t op_select(input logic rwwsre, input logic blbset,
                                    input logic pgwrt, input logic pgers,
                                    input logic spmen);
    if (pgers)       return OP_PGERS;
    else if (pgwrt)  return OP_PGWRT;
    else if (spmen)  return OP_SPMEN;
    else if (blbset) return OP_BLBSET;
    else if (rwwsre) return OP_RWWSRE;
    else             return OP_NONE;
  endfunction

endpackage

// File: rtl/pm_page_buf.sv
// rtl/pm_page_buf.sv - temporary page buffer with per-word valid bits
module pm_page_buf
  import spm_pm_engine_pkg::*;
#(
  parameter int PG_AW = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [PG_AW-1:0] waddr,
  input  logic [15:0]      wdata,
  input  logic             clr,
  input  logic [PG_AW-1:0] raddr,
  output logic [15:0]      rdata
);

  localparam int WORDS = 1 << PG_AW;

  logic [15:0]      mem_q [WORDS];
  logic [15:0]      mem_d [WORDS];
  logic [WORDS-1:0] valid_q;
  logic [WORDS-1:0] valid_d;

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (we) begin
      mem_d[waddr]   = wdata;
      valid_d[waddr] = 1'b1;
    end
    if (clr) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Data words need no reset: a clear valid bit masks them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = valid_q[raddr] ? mem_q[raddr] : ERASED_WORD;

endmodule

// File: rtl/spm_pm_engine.sv
// rtl/spm_pm_engine.sv - executes SPM operations: buffer fill, page erase/write, RWW re-enable, lock bits
module spm_pm_engine
  import spm_pm_engine_pkg::*;
#(
  parameter int         PM_AW    = 16,
  parameter int         PG_AW    = 6,
  parameter int         WR_DLY   = 3,
  parameter logic [7:0] BLB_INIT = 8'hFF
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [PM_AW-1:0] spm_adr,
  input  logic [15:0]      spm_out,
  input  logic             rwwsre_op,
  input  logic             blbset_op,
  input  logic             pgwrt_op,
  input  logic             pgers_op,
  input  logic             spmen_op,
  output logic             rwwsre_rdy,
  output logic             blbset_rdy,
  output logic             pgwrt_rdy,
  output logic             pgers_rdy,
  output logic             spmen_rdy,
  output logic [PM_AW-1:0] pm_adr,
  output logic [15:0]      pm_dout,
  output logic             pm_we,
  output logic             rww_busy,
  output logic [7:0]       lock_bits
);

  localparam int                DW       = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;
  localparam logic [DW-1:0]     DLY_LOAD = DW'((WR_DLY > 0) ? (WR_DLY - 1) : 0);
  localparam logic [PG_AW-1:0]  IDX_LAST = '1;

  state_t             state_q, state_d;
  op_t                op_q, op_d, op_sel;
  logic [PG_AW-1:0]   idx_q, idx_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [PM_AW-1:0]   base_q, base_d;
  logic               rww_busy_q, rww_busy_d;
  logic [7:0]         lock_q, lock_d;
  logic               pm_we_q, pm_we_d;
  logic [PM_AW-1:0]   pm_adr_q, pm_adr_d;
  logic [15:0]        pm_dout_q, pm_dout_d;
  logic [4:0]         rdy_q, rdy_d;
  logic               start_word;
  logic               buf_we, buf_clr;
  logic [15:0]        buf_rdata;
  logic               any_op;

  assign any_op = rwwsre_op | blbset_op | pgwrt_op | pgers_op | spmen_op;
  assign op_sel = op_select(rwwsre_op, blbset_op, pgwrt_op, pgers_op, spmen_op);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    base_d     = base_q;
    rww_busy_d = rww_busy_q;
    lock_d     = lock_q;
    rdy_d      = '0;
    start_word = 1'b0;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (op_sel != OP_NONE) begin
          op_d = op_sel;
          case (op_sel)
            OP_SPMEN: begin
              buf_we  = 1'b1;
              state_d = ST_DONE;
            end
            OP_BLBSET: begin
              lock_d  = lock_q & spm_out[7:0];
              state_d = ST_DONE;
            end
            OP_RWWSRE: begin
              rww_busy_d = 1'b0;
              buf_clr    = 1'b1;
              state_d    = ST_DONE;
            end
            default: begin
              base_d     = {spm_adr[PM_AW-1:PG_AW], {PG_AW{1'b0}}};
              idx_d      = '0;
              rww_busy_d = 1'b1;
              start_word = 1'b1;
              state_d    = ST_PROG;
            end
          endcase
        end
      end
      ST_PROG: begin
        if (WR_DLY == 0) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = idx_q + 1'b1;
            start_word = 1'b1;
          end
        end else begin
          dly_d   = DLY_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dly_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d      = idx_q + 1'b1;
            start_word = 1'b1;
            state_d    = ST_PROG;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_REL;
      ST_REL:  if (!any_op) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Completion pulse is registered, so it is raised on entry to DONE.
    if (state_d == ST_DONE) begin
      case (op_d)
        OP_RWWSRE: rdy_d[0] = 1'b1;
        OP_BLBSET: rdy_d[1] = 1'b1;
        OP_PGWRT: begin
          rdy_d[2] = 1'b1;
          buf_clr  = 1'b1;
        end
        OP_PGERS:  rdy_d[3] = 1'b1;
        OP_SPMEN:  rdy_d[4] = 1'b1;
        default:   rdy_d    = '0;
      endcase
    end
  end

  // Kept apart from the FSM block: the buffer read depends on idx_d.
  always_comb begin
    pm_we_d   = start_word;
    pm_adr_d  = pm_adr_q;
    pm_dout_d = pm_dout_q;
    if (start_word) begin
      pm_adr_d  = base_d | PM_AW'(idx_d);
      pm_dout_d = (op_d == OP_PGERS) ? ERASED_WORD : buf_rdata;
    end
  end

  pm_page_buf #(.PG_AW(PG_AW)) u_buf (
    .clk    (cp2),
    .resetn (ireset),
    .we     (buf_we),
    .waddr  (spm_adr[PG_AW-1:0]),
    .wdata  (spm_out),
    .clr    (buf_clr),
    .raddr  (idx_d),
    .rdata  (buf_rdata)
  );

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      idx_q      <= '0;
      dly_q      <= '0;
      base_q     <= '0;
      rww_busy_q <= 1'b0;
      lock_q     <= BLB_INIT;
      pm_we_q    <= 1'b0;
      pm_adr_q   <= '0;
      pm_dout_q  <= '0;
      rdy_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
      base_q     <= base_d;
      rww_busy_q <= rww_busy_d;
      lock_q     <= lock_d;
      pm_we_q    <= pm_we_d;
      pm_adr_q   <= pm_adr_d;
      pm_dout_q  <= pm_dout_d;
      rdy_q      <= rdy_d;
    end
  end

  assign rwwsre_rdy = rdy_q[0];
  assign blbset_rdy = rdy_q[1];
  assign pgwrt_rdy  = rdy_q[2];
  assign pgers_rdy  = rdy_q[3];
  assign spmen_rdy  = rdy_q[4];
  assign pm_we      = pm_we_q;
  assign pm_adr     = pm_adr_q;
  assign pm_dout    = pm_dout_q;
  assign rww_busy   = rww_busy_q;
  assign lock_bits  = lock_q;

endmodule

// File: tb/tb_spm_pm_engine.sv
// tb/tb_spm_pm_engine.sv - scoreboard testbench for spm_pm_engine
module tb_spm_pm_engine;

  logic        cp2 = 1'b0;
  logic        ireset;
  logic [15:0] spm_adr, spm_out;
  logic [4:0]  ops_drv;
  logic        rwwsre_rdy, blbset_rdy, pgwrt_rdy, pgers_rdy, spmen_rdy;
  logic [15:0] pm_adr, pm_dout;
  logic        pm_we, rww_busy;
  logic [7:0]  lock_bits;
  logic [4:0]  rdy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [15:0] bm_data [64];
  logic        bm_valid [64];
  logic [7:0]  m_lock;
  logic        m_rww;

  int cyc = 0;
  int last_we_cyc = 0;
  int we_seq = 0;

  always #5 cp2 = ~cp2;

  spm_pm_engine dut (
    .cp2        (cp2),
    .ireset     (ireset),
    .spm_adr    (spm_adr),
    .spm_out    (spm_out),
    .rwwsre_op  (ops_drv[0]),
    .blbset_op  (ops_drv[1]),
    .pgwrt_op   (ops_drv[2]),
    .pgers_op   (ops_drv[3]),
    .spmen_op   (ops_drv[4]),
    .rwwsre_rdy (rwwsre_rdy),
    .blbset_rdy (blbset_rdy),
    .pgwrt_rdy  (pgwrt_rdy),
    .pgers_rdy  (pgers_rdy),
    .spmen_rdy  (spmen_rdy),
    .pm_adr     (pm_adr),
    .pm_dout    (pm_dout),
    .pm_we      (pm_we),
    .rww_busy   (rww_busy),
    .lock_bits  (lock_bits)
  );

  assign rdy_vec = {spmen_rdy, pgers_rdy, pgwrt_rdy, blbset_rdy, rwwsre_rdy};

  // Write-port monitor: every strobe is popped against the scoreboard.
  always @(negedge cp2) begin
    logic [31:0] e;
    cyc++;
    if (pm_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pm_we_unexpected: adr=%h data=%h, required no write", pm_adr, pm_dout);
      end else begin
        e = exp_q.pop_front();
        if ({pm_adr, pm_dout} !== e) begin
          n_fail++;
          $display("FAIL pm_write: adr=%h data=%h, required adr=%h data=%h",
                   pm_adr, pm_dout, e[31:16], e[15:0]);
        end
      end
      if (we_seq > 0) begin
        n_checks++;
        if (cyc - last_we_cyc !== 4) begin
          n_fail++;
          $display("FAIL pm_we_spacing: %0d cycles, required 4", cyc - last_we_cyc);
        end
      end
      we_seq++;
      last_we_cyc = cyc;
    end
  end

  function automatic int winner(input logic [4:0] mask);
    if (mask[3])      return 3;
    else if (mask[2]) return 2;
    else if (mask[4]) return 4;
    else if (mask[1]) return 1;
    else              return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bm_valid[i] = 1'b0;
    m_lock = 8'hFF;
    m_rww  = 1'b0;
  endtask

  task automatic model_accept(input int win, input logic [15:0] adr, input logic [15:0] dat);
    logic [15:0] base;
    logic [15:0] d;
    case (win)
      4: begin
        bm_data[adr[5:0]]  = dat;
        bm_valid[adr[5:0]] = 1'b1;
      end
      1: m_lock = m_lock & dat[7:0];
      0: begin
        m_rww = 1'b0;
        for (int i = 0; i < 64; i++) bm_valid[i] = 1'b0;
      end
      default: begin
        base  = adr & 16'hFFC0;
        m_rww = 1'b1;
        for (int i = 0; i < 64; i++) begin
          d = (win == 3 || !bm_valid[i]) ? 16'hFFFF : bm_data[i];
          exp_q.push_back({base | 16'(i), d});
        end
        if (win == 2) for (int i = 0; i < 64; i++) bm_valid[i] = 1'b0;
      end
    endcase
  endtask

  task automatic run_op(input logic [4:0] mask, input logic [15:0] adr, input logic [15:0] dat,
                        input int hold, input int exp_lat, input string name);
    int win, c, first, nrdy, nother, exp_we;
    win = winner(mask);
    model_accept(win, adr, dat);
    exp_we = (win == 2 || win == 3) ? 64 : 0;
    @(negedge cp2);
    we_seq  = 0;
    spm_adr = adr;
    spm_out = dat;
    ops_drv = mask;
    c = 0; first = -1; nrdy = 0; nother = 0;
    while (c < 2000) begin
      @(negedge cp2);
      c++;
      // Operands change after acceptance; a re-trigger would write a different word.
      if (c == 1) begin
        spm_adr = adr ^ 16'h0001;
        spm_out = 16'hDEAD;
      end
      if (c >= hold) ops_drv = '0;
      if (rdy_vec[win]) begin
        nrdy++;
        if (first < 0) first = c;
      end
      if ((rdy_vec & ~(5'b1 << win)) != 5'b0) nother++;
      if (first >= 0 && c >= hold && c >= first + 3) break;
    end
    ops_drv = '0;
    n_checks++;
    if (first !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: %0d cycles, required %0d", name, first, exp_lat);
    end
    n_checks++;
    if (nrdy !== 1) begin
      n_fail++;
      $display("FAIL %s_rdy_pulses: %0d, required 1", name, nrdy);
    end
    n_checks++;
    if (nother !== 0) begin
      n_fail++;
      $display("FAIL %s_other_rdy: %0d cycles, required 0", name, nother);
    end
    n_checks++;
    if (we_seq !== exp_we) begin
      n_fail++;
      $display("FAIL %s_we_count: %0d, required %0d", name, we_seq, exp_we);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_sb_left: %0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (rww_busy !== m_rww || lock_bits !== m_lock) begin
      n_fail++;
      $display("FAIL %s_flags: rww=%b lock=%h, required rww=%b lock=%h",
               name, rww_busy, lock_bits, m_rww, m_lock);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({rdy_vec, pm_we, pm_adr, pm_dout, rww_busy, lock_bits} !==
        {5'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL %s: rdy=%b we=%b adr=%h dout=%h rww=%b lock=%h, required 0 0 0000 0000 0 ff",
               name, rdy_vec, pm_we, pm_adr, pm_dout, rww_busy, lock_bits);
    end
  endtask

  task automatic test_reset();
    ireset  = 1'b0;
    ops_drv = '0;
    spm_adr = '0;
    spm_out = '0;
    model_reset();
    repeat (3) @(negedge cp2);
    check_reset_outputs("reset_values");
    ireset = 1'b1;
    repeat (2) @(negedge cp2);
  endtask

  task automatic test_fill_write();
    run_op(5'b10000, 16'h0105, 16'hA5A5, 1, 1, "spmen_a");
    run_op(5'b10000, 16'h0107, 16'h1234, 1, 1, "spmen_b");
    run_op(5'b00100, 16'h0100, 16'h0000, 1, 257, "pgwrt_fill");
    run_op(5'b00100, 16'h0100, 16'h0000, 1, 257, "pgwrt_empty");
  endtask

  task automatic test_erase();
    run_op(5'b01000, 16'h02C7, 16'h0000, 1, 257, "pgers");
    run_op(5'b00001, 16'h0000, 16'h0000, 1, 1, "rwwsre");
  endtask

  task automatic test_lock();
    run_op(5'b00010, 16'h0000, 16'h00F3, 1, 1, "blbset_a");
    run_op(5'b00010, 16'h0000, 16'h00FD, 1, 1, "blbset_b");
  endtask

  task automatic test_held_op();
    run_op(5'b10000, 16'h0003, 16'h5A5A, 7, 1, "spmen_held");
    run_op(5'b00100, 16'h0040, 16'h0000, 1, 257, "pgwrt_held");
  endtask

  task automatic test_priority();
    run_op(5'b11000, 16'h0080, 16'h7777, 1, 257, "prio");
    run_op(5'b00100, 16'h00C0, 16'h0000, 1, 257, "pgwrt_prio");
  endtask

  task automatic test_reset_mid();
    int n, c;
    run_op(5'b10000, 16'h0000, 16'h1111, 1, 1, "spmen_pre");
    model_accept(3, 16'h0300, 16'h0000);
    @(negedge cp2);
    we_seq  = 0;
    spm_adr = 16'h0300;
    ops_drv = 5'b01000;
    n = 0; c = 0;
    while (n < 10 && c < 200) begin
      @(negedge cp2);
      c++;
      ops_drv = '0;
      if (pm_we) n++;
    end
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL reset_mid_reach: %0d writes, required 10", n);
    end
    ireset = 1'b0;
    @(negedge cp2);
    exp_q.delete();
    model_reset();
    check_reset_outputs("reset_mid_values");
    @(negedge cp2);
    ireset = 1'b1;
    @(negedge cp2);
    n_checks++;
    if (pm_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_we: %b, required 0", pm_we);
    end
    run_op(5'b10000, 16'h0001, 16'h2222, 1, 1, "spmen_post");
    run_op(5'b00100, 16'h0400, 16'h0000, 1, 257, "pgwrt_post");
  endtask

  initial begin
    test_reset();
    test_fill_write();
    test_erase();
    test_lock();
    test_held_op();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
